// File: rtl/mem_arbiter.sv
// Two-requester (IFU fetch / LSU load-store) arbiter in front of a single memory port.
// Round-robin on ties, one outstanding transaction, wait-cycle timeout with error response.
module mem_arbiter #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        core_clk,
   input  logic        core_rst,
   input  logic        ifu_arb_valid,
   input  logic [63:0] ifu_arb_addr,
   output logic [31:0] arb_ifu_data,
   output logic        arb_ifu_resp_valid,
   output logic        arb_ifu_err,
   input  logic        lsu_arb_valid,
   input  logic [63:0] lsu_arb_addr,
   input  logic        lsu_arb_wen,
   input  logic [63:0] lsu_arb_wdata,
   input  logic [7:0]  lsu_arb_wmask,
   output logic [63:0] arb_lsu_data,
   output logic        arb_lsu_resp_valid,
   output logic        arb_lsu_err,
   output logic        arb_mem_valid,
   output logic [63:0] arb_mem_addr,
   output logic        arb_mem_wen,
   output logic [63:0] arb_mem_wdata,
   output logic [7:0]  arb_mem_wmask,
   input  logic        mem_arb_ready,
   input  logic        mem_arb_valid,
   input  logic [63:0] mem_arb_data
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT_CYC - 1);

   state_t      r_state, w_next;
   logic        r_last_grant;   // 0 = IFU, 1 = LSU
   logic        r_owner;
   logic [63:0] r_addr;
   logic        r_wen;
   logic [63:0] r_wdata;
   logic [7:0]  r_wmask;
   logic [15:0] r_cnt;
   logic        r_ifu_resp, r_ifu_err, r_lsu_resp, r_lsu_err;
   logic [31:0] r_ifu_data;
   logic [63:0] r_lsu_data;

   logic        w_ifu_req, w_lsu_req, w_any_req, w_grant_lsu, w_timeout;

   // A requester still sees valid high during its own response pulse; mask it so
   // the completed request is not granted a second time.
   assign w_ifu_req   = ifu_arb_valid & ~r_ifu_resp;
   assign w_lsu_req   = lsu_arb_valid & ~r_lsu_resp;
   assign w_any_req   = w_ifu_req | w_lsu_req;
   assign w_grant_lsu = w_lsu_req & (~w_ifu_req | ~r_last_grant);
   assign w_timeout   = (r_cnt == LP_CNT_LAST);

   always_ff @(posedge core_clk or posedge core_rst) begin
      if (core_rst) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_any_req) w_next = S_REQ;
         S_REQ:   if (mem_arb_ready) w_next = S_WAIT;
         S_WAIT:  if (mem_arb_valid || w_timeout) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      arb_mem_valid      = (r_state == S_REQ);
      arb_mem_addr       = r_addr;
      arb_mem_wen        = r_wen;
      arb_mem_wdata      = r_wdata;
      arb_mem_wmask      = r_wmask;
      arb_ifu_resp_valid = r_ifu_resp;
      arb_ifu_err        = r_ifu_err;
      arb_ifu_data       = r_ifu_data;
      arb_lsu_resp_valid = r_lsu_resp;
      arb_lsu_err        = r_lsu_err;
      arb_lsu_data       = r_lsu_data;
   end

   always_ff @(posedge core_clk or posedge core_rst) begin
      if (core_rst) begin
         r_last_grant <= 1'b0;
         r_owner      <= 1'b0;
         r_addr       <= '0;
         r_wen        <= 1'b0;
         r_wdata      <= '0;
         r_wmask      <= '0;
         r_cnt        <= '0;
         r_ifu_resp   <= 1'b0;
         r_ifu_err    <= 1'b0;
         r_ifu_data   <= '0;
         r_lsu_resp   <= 1'b0;
         r_lsu_err    <= 1'b0;
         r_lsu_data   <= '0;
      end else begin
         r_ifu_resp <= 1'b0;
         r_lsu_resp <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_owner      <= w_grant_lsu;
                  r_last_grant <= w_grant_lsu;
                  r_cnt        <= '0;
                  if (w_grant_lsu) begin
                     r_addr  <= lsu_arb_addr;
                     r_wen   <= lsu_arb_wen;
                     r_wdata <= lsu_arb_wdata;
                     r_wmask <= lsu_arb_wmask;
                  end else begin
                     r_addr  <= ifu_arb_addr;
                     r_wen   <= 1'b0;
                     r_wdata <= '0;
                     r_wmask <= '0;
                  end
               end
            end
            S_REQ: begin
               if (mem_arb_ready) r_cnt <= '0;
            end
            S_WAIT: begin
               // A response wins over a timeout landing in the same cycle.
               if (mem_arb_valid || w_timeout) begin
                  if (r_owner) begin
                     r_lsu_resp <= 1'b1;
                     r_lsu_err  <= ~mem_arb_valid;
                     r_lsu_data <= mem_arb_valid ? mem_arb_data : '0;
                  end else begin
                     r_ifu_resp <= 1'b1;
                     r_ifu_err  <= ~mem_arb_valid;
                     if (!mem_arb_valid) r_ifu_data <= '0;
                     else if (r_addr[2]) r_ifu_data <= mem_arb_data[63:32];
                     else                r_ifu_data <= mem_arb_data[31:0];
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT_CYC=4): fetch, round-robin, store hold,
// timeout boundary and mid-transaction reset.
module tb_mem_arbiter;

   logic        core_clk = 1'b0;
   logic        core_rst;
   logic        ifu_arb_valid;
   logic [63:0] ifu_arb_addr;
   logic [31:0] arb_ifu_data;
   logic        arb_ifu_resp_valid, arb_ifu_err;
   logic        lsu_arb_valid;
   logic [63:0] lsu_arb_addr;
   logic        lsu_arb_wen;
   logic [63:0] lsu_arb_wdata;
   logic [7:0]  lsu_arb_wmask;
   logic [63:0] arb_lsu_data;
   logic        arb_lsu_resp_valid, arb_lsu_err;
   logic        arb_mem_valid;
   logic [63:0] arb_mem_addr;
   logic        arb_mem_wen;
   logic [63:0] arb_mem_wdata;
   logic [7:0]  arb_mem_wmask;
   logic        mem_arb_ready, mem_arb_valid;
   logic [63:0] mem_arb_data;

   int n_chk = 0;
   int n_fail = 0;

   mem_arbiter #(.TIMEOUT_CYC(4)) dut (
      .core_clk(core_clk), .core_rst(core_rst),
      .ifu_arb_valid(ifu_arb_valid), .ifu_arb_addr(ifu_arb_addr),
      .arb_ifu_data(arb_ifu_data), .arb_ifu_resp_valid(arb_ifu_resp_valid), .arb_ifu_err(arb_ifu_err),
      .lsu_arb_valid(lsu_arb_valid), .lsu_arb_addr(lsu_arb_addr), .lsu_arb_wen(lsu_arb_wen),
      .lsu_arb_wdata(lsu_arb_wdata), .lsu_arb_wmask(lsu_arb_wmask),
      .arb_lsu_data(arb_lsu_data), .arb_lsu_resp_valid(arb_lsu_resp_valid), .arb_lsu_err(arb_lsu_err),
      .arb_mem_valid(arb_mem_valid), .arb_mem_addr(arb_mem_addr), .arb_mem_wen(arb_mem_wen),
      .arb_mem_wdata(arb_mem_wdata), .arb_mem_wmask(arb_mem_wmask),
      .mem_arb_ready(mem_arb_ready), .mem_arb_valid(mem_arb_valid), .mem_arb_data(mem_arb_data)
   );

   always #5 core_clk = ~core_clk;

   task automatic tick();
      @(posedge core_clk);
      #1;
   endtask

   task automatic test_reset();
      core_rst = 1'b1;
      ifu_arb_valid = 1'b0; ifu_arb_addr = '0;
      lsu_arb_valid = 1'b0; lsu_arb_addr = '0; lsu_arb_wen = 1'b0; lsu_arb_wdata = '0; lsu_arb_wmask = '0;
      mem_arb_ready = 1'b0; mem_arb_valid = 1'b0; mem_arb_data = '0;
      tick(); tick();
      n_chk++; if (arb_mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid: got %0h want 0", arb_mem_valid); end
      n_chk++; if (arb_mem_addr !== 64'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %0h want 0", arb_mem_addr); end
      n_chk++; if ({arb_ifu_resp_valid, arb_lsu_resp_valid, arb_ifu_err, arb_lsu_err} !== 4'b0) begin
         n_fail++; $display("FAIL reset_resp: got %0b want 0000", {arb_ifu_resp_valid, arb_lsu_resp_valid, arb_ifu_err, arb_lsu_err}); end
      n_chk++; if (arb_ifu_data !== 32'h0 || arb_lsu_data !== 64'h0) begin
         n_fail++; $display("FAIL reset_data: got %0h/%0h want 0/0", arb_ifu_data, arb_lsu_data); end
      core_rst = 1'b0;
      // stale response in IDLE must be ignored
      mem_arb_valid = 1'b1; mem_arb_data = 64'h5555_5555_5555_5555;
      tick();
      n_chk++; if (arb_ifu_resp_valid !== 1'b0 || arb_lsu_resp_valid !== 1'b0) begin
         n_fail++; $display("FAIL stale_idle: got %0b%0b want 00", arb_ifu_resp_valid, arb_lsu_resp_valid); end
      mem_arb_valid = 1'b0;
      tick();
   endtask

   task automatic test_single_fetch();
      ifu_arb_valid = 1'b1; ifu_arb_addr = 64'h8000_0004;
      tick();
      n_chk++; if (arb_mem_valid !== 1'b1 || arb_mem_addr !== 64'h8000_0004) begin
         n_fail++; $display("FAIL fetch_req: got v=%0h a=%0h want v=1 a=80000004", arb_mem_valid, arb_mem_addr); end
      n_chk++; if (arb_mem_wen !== 1'b0 || arb_mem_wmask !== 8'h0) begin
         n_fail++; $display("FAIL fetch_wen_mask: got %0h/%0h want 0/0", arb_mem_wen, arb_mem_wmask); end
      mem_arb_ready = 1'b1;
      tick();
      n_chk++; if (arb_mem_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_wait_valid: got %0h want 0", arb_mem_valid); end
      mem_arb_ready = 1'b0; mem_arb_valid = 1'b1; mem_arb_data = 64'h1111_2222_3333_4444;
      tick();
      n_chk++; if (arb_ifu_resp_valid !== 1'b1 || arb_ifu_data !== 32'h1111_2222 || arb_ifu_err !== 1'b0) begin
         n_fail++; $display("FAIL fetch_resp: got v=%0h d=%0h e=%0h want v=1 d=11112222 e=0", arb_ifu_resp_valid, arb_ifu_data, arb_ifu_err); end
      n_chk++; if (arb_lsu_resp_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_nonowner: got %0h want 0", arb_lsu_resp_valid); end
      mem_arb_valid = 1'b0; ifu_arb_valid = 1'b0;
      tick();
      n_chk++; if (arb_ifu_resp_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse_width: got %0h want 0", arb_ifu_resp_valid); end
      n_chk++; if (arb_mem_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_no_regrant: got %0h want 0", arb_mem_valid); end
   endtask

   task automatic test_round_robin();
      lsu_arb_valid = 1'b1; lsu_arb_addr = 64'h100; lsu_arb_wen = 1'b0;
      ifu_arb_valid = 1'b1; ifu_arb_addr = 64'h200;
      tick();
      n_chk++; if (arb_mem_addr !== 64'h100) begin n_fail++; $display("FAIL rr_first_lsu: got %0h want 100", arb_mem_addr); end
      mem_arb_ready = 1'b1; tick();
      mem_arb_ready = 1'b0; mem_arb_valid = 1'b1; mem_arb_data = 64'h0123_4567_89AB_CDEF;
      tick();
      n_chk++; if (arb_lsu_resp_valid !== 1'b1 || arb_lsu_data !== 64'h0123_4567_89AB_CDEF || arb_ifu_resp_valid !== 1'b0) begin
         n_fail++; $display("FAIL rr_lsu_resp: got v=%0h d=%0h iv=%0h want v=1 d=0123456789abcdef iv=0",
                            arb_lsu_resp_valid, arb_lsu_data, arb_ifu_resp_valid); end
      lsu_arb_valid = 1'b0; mem_arb_valid = 1'b0;
      tick();
      n_chk++; if (arb_mem_valid !== 1'b1 || arb_mem_addr !== 64'h200) begin
         n_fail++; $display("FAIL rr_second_ifu: got v=%0h a=%0h want v=1 a=200", arb_mem_valid, arb_mem_addr); end
      mem_arb_ready = 1'b1; tick();
      mem_arb_ready = 1'b0; mem_arb_valid = 1'b1; mem_arb_data = 64'hAAAA_BBBB_CCCC_DDDD;
      tick();
      n_chk++; if (arb_ifu_resp_valid !== 1'b1 || arb_ifu_data !== 32'hCCCC_DDDD || arb_lsu_resp_valid !== 1'b0) begin
         n_fail++; $display("FAIL rr_ifu_resp: got v=%0h d=%0h lv=%0h want v=1 d=ccccdddd lv=0",
                            arb_ifu_resp_valid, arb_ifu_data, arb_lsu_resp_valid); end
      ifu_arb_valid = 1'b0; mem_arb_valid = 1'b0;
      tick();
      lsu_arb_valid = 1'b1; ifu_arb_valid = 1'b1;
      tick();
      n_chk++; if (arb_mem_addr !== 64'h100) begin n_fail++; $display("FAIL rr_third_lsu: got %0h want 100", arb_mem_addr); end
      mem_arb_ready = 1'b1; tick();
      mem_arb_ready = 1'b0; mem_arb_valid = 1'b1; tick();
      lsu_arb_valid = 1'b0; ifu_arb_valid = 1'b0; mem_arb_valid = 1'b0;
      tick(); tick();
   endtask

   task automatic test_store();
      int pulses = 0;
      lsu_arb_valid = 1'b1; lsu_arb_addr = 64'h3000; lsu_arb_wen = 1'b1;
      lsu_arb_wdata = 64'hDEAD_BEEF_0000_0001; lsu_arb_wmask = 8'h0F;
      tick();
      for (int i = 0; i < 4; i++) begin
         n_chk++; if (arb_mem_valid !== 1'b1 || arb_mem_addr !== 64'h3000 || arb_mem_wen !== 1'b1 ||
                      arb_mem_wdata !== 64'hDEAD_BEEF_0000_0001 || arb_mem_wmask !== 8'h0F) begin
            n_fail++; $display("FAIL store_hold[%0d]: got v=%0h a=%0h w=%0h d=%0h m=%0h want v=1 a=3000 w=1 d=deadbeef00000001 m=0f",
                               i, arb_mem_valid, arb_mem_addr, arb_mem_wen, arb_mem_wdata, arb_mem_wmask); end
         if (i == 3) mem_arb_ready = 1'b1;
         tick();
      end
      mem_arb_ready = 1'b0; mem_arb_valid = 1'b1; mem_arb_data = 64'h77;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (arb_lsu_resp_valid === 1'b1) pulses++;
         mem_arb_valid = 1'b0; lsu_arb_valid = 1'b0;
      end
      n_chk++; if (pulses !== 1) begin n_fail++; $display("FAIL store_pulses: got %0d want 1", pulses); end
      n_chk++; if (arb_lsu_err !== 1'b0) begin n_fail++; $display("FAIL store_err: got %0h want 0", arb_lsu_err); end
   endtask

   task automatic test_timeout();
      mem_arb_data = 64'hFFFF_FFFF_FFFF_FFFF;
      ifu_arb_valid = 1'b1; ifu_arb_addr = 64'h40;
      tick();
      mem_arb_ready = 1'b1; tick();
      mem_arb_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_chk++; if (arb_ifu_resp_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_early[%0d]: got %0h want 0", i, arb_ifu_resp_valid); end
      end
      tick();
      n_chk++; if (arb_ifu_resp_valid !== 1'b1 || arb_ifu_err !== 1'b1 || arb_ifu_data !== 32'h0) begin
         n_fail++; $display("FAIL timeout_resp: got v=%0h e=%0h d=%0h want v=1 e=1 d=0", arb_ifu_resp_valid, arb_ifu_err, arb_ifu_data); end
      ifu_arb_valid = 1'b0;
      tick();
      n_chk++; if (arb_ifu_resp_valid !== 1'b0 || arb_mem_valid !== 1'b0) begin
         n_fail++; $display("FAIL timeout_idle: got rv=%0h mv=%0h want 0/0", arb_ifu_resp_valid, arb_mem_valid); end
      ifu_arb_valid = 1'b1; ifu_arb_addr = 64'h44;
      tick();
      mem_arb_ready = 1'b1; tick();
      mem_arb_ready = 1'b0;
      tick(); tick(); tick();
      mem_arb_valid = 1'b1; mem_arb_data = 64'h9999_8888_7777_6666;
      tick();
      n_chk++; if (arb_ifu_resp_valid !== 1'b1 || arb_ifu_err !== 1'b0 || arb_ifu_data !== 32'h9999_8888) begin
         n_fail++; $display("FAIL timeout_race: got v=%0h e=%0h d=%0h want v=1 e=0 d=99998888", arb_ifu_resp_valid, arb_ifu_err, arb_ifu_data); end
      mem_arb_valid = 1'b0; ifu_arb_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      lsu_arb_valid = 1'b1; lsu_arb_addr = 64'h500; lsu_arb_wen = 1'b0; lsu_arb_wmask = '0; lsu_arb_wdata = '0;
      tick();
      mem_arb_ready = 1'b1; tick();
      mem_arb_ready = 1'b0;
      tick();
      core_rst = 1'b1; lsu_arb_valid = 1'b0;
      #1;
      n_chk++; if (arb_mem_addr !== 64'h0 || arb_lsu_data !== 64'h0 || arb_ifu_data !== 32'h0) begin
         n_fail++; $display("FAIL rst_async: got a=%0h ld=%0h id=%0h want 0/0/0", arb_mem_addr, arb_lsu_data, arb_ifu_data); end
      tick();
      core_rst = 1'b0; mem_arb_valid = 1'b1; mem_arb_data = 64'h1234;
      tick();
      n_chk++; if (arb_ifu_resp_valid !== 1'b0 || arb_lsu_resp_valid !== 1'b0 || arb_mem_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_no_pulse: got iv=%0h lv=%0h mv=%0h want 0/0/0", arb_ifu_resp_valid, arb_lsu_resp_valid, arb_mem_valid); end
      mem_arb_valid = 1'b0;
      ifu_arb_valid = 1'b1; ifu_arb_addr = 64'h600; lsu_arb_valid = 1'b1; lsu_arb_addr = 64'h700;
      tick();
      n_chk++; if (arb_mem_valid !== 1'b1 || arb_mem_addr !== 64'h700) begin
         n_fail++; $display("FAIL rst_last_grant: got v=%0h a=%0h want v=1 a=700", arb_mem_valid, arb_mem_addr); end
      ifu_arb_valid = 1'b0; lsu_arb_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_round_robin();
      test_store();
      test_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, SHALL set the maximum number of WAIT cycles before a transaction is aborted (legal range 1..65535).
REQ-002 Ports SHALL be:
- core_clk  in  1  core clock, rising-edge
- core_rst  in  1  reset, asynchronous, active-high
- ifu_arb_valid  in  1  fetch request, held until ifu_arb_resp_valid
- ifu_arb_addr  in  64  fetch address
- arb_ifu_data  out  32  fetched instruction
- arb_ifu_resp_valid  out  1  fetch response pulse
- arb_ifu_err  out  1  fetch timed out, qualified by arb_ifu_resp_valid
- lsu_arb_valid  in  1  load/store request, held until arb_lsu_resp_valid
- lsu_arb_addr  in  64  data address
- lsu_arb_wen  in  1  1 = store
- lsu_arb_wdata  in  64  store data
- lsu_arb_wmask  in  8  store byte mask
- arb_lsu_data  out  64  load data
- arb_lsu_resp_valid  out  1  data response pulse
- arb_lsu_err  out  1  data timed out, qualified by arb_lsu_resp_valid
- arb_mem_valid  out  1  memory request
- arb_mem_addr  out  64  memory address
- arb_mem_wen  out  1  memory write enable
- arb_mem_wdata  out  64  memory write data
- arb_mem_wmask  out  8  memory byte mask
- mem_arb_ready  in  1  memory accepts request this cycle
- mem_arb_valid  in  1  memory response valid
- mem_arb_data  in  64  memory read data

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, REQ, WAIT.
REQ-004 IDLE: if any requester is valid at a rising edge, the arbiter SHALL latch the winner's id, addr, wen, wdata, and wmask and move to REQ; otherwise it SHALL stay in IDLE.
REQ-005 Arbitration: a single requester SHALL win; on a tie, the requester not granted last SHALL win (round-robin via a 1-bit last_grant register updated on every grant).
REQ-006 REQ: arb_mem_valid SHALL be 1 with the latched fields on arb_mem_*; on mem_arb_ready=1 the FSM SHALL move to WAIT; otherwise it SHALL hold REQ with stable outputs.
REQ-007 In IDLE and WAIT, arb_mem_valid SHALL be 0.
REQ-008 For an IFU grant, arb_mem_wen SHALL be 0 and arb_mem_wmask SHALL be 0.
REQ-009 WAIT: on mem_arb_valid=1, the owner's resp_valid SHALL pulse for exactly 1 cycle (registered, the cycle after the response), err SHALL be 0, and the FSM SHALL return to IDLE.
REQ-010 IFU data SHALL be mem_arb_data[31:0] when latched addr[2]=0, and mem_arb_data[63:32] when addr[2]=1.
REQ-011 LSU data SHALL be the full mem_arb_data; for stores, the data SHALL be forwarded unchanged and the LSU SHALL ignore it.
REQ-012 A 16-bit wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without a response.
REQ-013 When the counter reaches TIMEOUT_CYC, the owner's resp_valid SHALL pulse with err=1 and data=0, and the FSM SHALL return to IDLE.
REQ-014 A response and a timeout in the same cycle SHALL be treated as a normal response (err=0).
REQ-015 mem_arb_valid in IDLE or REQ SHALL be ignored, as a stale response.
REQ-016 Requests arriving while not in IDLE SHALL be held off with no loss, because requesters hold valid; a requester deasserting before its grant SHALL be a protocol violation with undefined behaviour.
REQ-017 The non-owner's resp_valid SHALL never assert.
REQ-018 The request-to-response latency SHALL be a minimum of 3 cycles: grant edge, REQ cycle, response cycle, then registered pulse.
REQ-019 After a resp pulse, the FSM SHALL be in IDLE and SHALL sample the next request on the following edge; back-to-back grants SHALL occur every 4 cycles minimum.

Reset
REQ-020 core_rst=1 SHALL asynchronously force: state IDLE; last_grant=IFU (so the LSU wins the first tie); counter 0; all outputs 0; all latched fields 0.
REQ-021 Reset mid-transaction SHALL abandon that transaction with no response pulse, and any memory response after reset release SHALL be ignored per REQ-015.

Verification
REQ-022 Single fetch: IFU addr 0x80000004, ready=1, memory returns 0x1111_2222_3333_4444 -> arb_ifu_data=0x11112222, err=0, pulse exactly 1 cycle.
REQ-023 Simultaneous requests after reset -> LSU granted first, IFU second; then another tie -> LSU.
REQ-024 Store: LSU wen=1, wdata=0xDEAD_BEEF_0000_0001, wmask=0x0F, ready delayed 3 cycles -> arb_mem_* stable throughout REQ, one arb_lsu_resp_valid pulse.
REQ-025 Timeout with TIMEOUT_CYC=4 and no response -> arb_ifu_resp_valid with err=1 and data=0 after 4 WAIT cycles; a response arriving exactly at the timeout cycle -> err=0.
REQ-026 Assert core_rst during WAIT, then deliver mem_arb_valid after release -> no resp pulses, state IDLE, last_grant=IFU.
